// File: rtl/stage_sequencer.sv
// stage_sequencer: multi-cycle IF/ID/EX/MEM/WB instruction sequencer with halt and retire count.
`ifndef STAGE_COUNT
`define STAGE_COUNT 3
`define STAGE_IF 3'd0
`define STAGE_ID 3'd1
`define STAGE_EX 3'd2
`define STAGE_MEM 3'd3
`define STAGE_WB 3'd4
`endif
`ifndef OPCODE_COUNT
`define OPCODE_COUNT 4
`define TYPE_ADD 4'd0
`define TYPE_RCALL 4'd8
`define TYPE_RET 4'd9
`endif

module stage_sequencer #(
  parameter int RETIRED_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [`OPCODE_COUNT-1:0]   opcode_type,
  input  logic                       mem_wait,
  input  logic                       halt_req,
  input  logic                       wake,
  output logic [`STAGE_COUNT-1:0]    pipeline_stage,
  output logic                       cycle_count,
  output logic                       fetch_en,
  output logic                       instr_done,
  output logic                       halted,
  output logic [RETIRED_WIDTH-1:0]   retired
);
  typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM0, S_MEM1, S_WB, S_HALT} state_t;
  state_t state, state_next;
  logic two_mem;
  assign two_mem = opcode_type == `TYPE_RCALL || opcode_type == `TYPE_RET;
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IF;
      retired <= '0;
    end else begin
      state <= state_next;
      if (state == S_WB) retired <= retired + 1'b1;
    end
  end
  always_comb begin
    state_next = state;
    case (state)
      S_IF:   state_next = S_ID;
      S_ID:   state_next = S_EX;
      S_EX:   state_next = S_MEM0;
      S_MEM0: state_next = mem_wait ? S_MEM0 : two_mem ? S_MEM1 : S_WB;
      S_MEM1: state_next = mem_wait ? S_MEM1 : S_WB;
      S_WB:   state_next = halt_req ? S_HALT : S_IF;
      S_HALT: state_next = wake ? S_IF : S_HALT;
      default: state_next = S_IF;
    endcase
  end
  assign pipeline_stage = state == S_ID ? `STAGE_ID :
                          state == S_EX ? `STAGE_EX :
                          (state == S_MEM0 || state == S_MEM1) ? `STAGE_MEM :
                          state == S_WB ? `STAGE_WB : `STAGE_IF;
  assign cycle_count = state == S_MEM1;
  assign fetch_en    = state == S_IF;
  assign instr_done  = state == S_WB;
  assign halted      = state == S_HALT;
endmodule
